// File: rtl/apb_reg_slave.sv
// APB completer with NUM_REGS byte-strobed registers, WAIT_STATES wait cycles and pslverr on bad addresses.
// Optional build macro APB_PRIV_ONLY_EN: reject every transfer that is not privileged (pprot[0]=0).
module apb_reg_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    input  logic [2:0]            pprot,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [1:0]            o_dbg_state
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] REG_SPAN = ADDR_WIDTH'(NUM_REGS * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_err;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_setup;
    logic                  w_access;
    logic [IDX_W-1:0]      w_dec_idx;
    logic                  w_dec_err;
    logic [IDX_W-1:0]      w_cur_idx;
    logic                  w_cur_err;
    logic                  w_cur_write;
    logic                  w_enter_done;
    logic                  w_commit;
    logic                  w_unused;

    assign w_setup   = psel & ~penable;
    assign w_access  = psel & penable;
    assign w_dec_idx = paddr[IDX_W+1:2];

`ifdef APB_PRIV_ONLY_EN
    assign w_dec_err = (paddr[1:0] != 2'b00) | (paddr >= REG_SPAN) | ~pprot[0];
`else
    assign w_dec_err = (paddr[1:0] != 2'b00) | (paddr >= REG_SPAN);
`endif
    assign w_unused = &{1'b0, pprot};

    // With zero wait states DONE is entered straight from the setup cycle,
    // so the live decode is used there instead of the captured one.
    assign w_cur_idx   = (r_state == ST_IDLE) ? w_dec_idx : r_idx;
    assign w_cur_err   = (r_state == ST_IDLE) ? w_dec_err : r_err;
    assign w_cur_write = (r_state == ST_IDLE) ? pwrite    : r_write;

    assign w_enter_done = (w_next == ST_DONE);
    assign w_commit     = (r_state == ST_DONE) & w_access & pwrite & ~r_err;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    if (WAIT_STATES == 0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_WAIT;
                        w_cnt_next = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                if (!w_access) begin
                    w_next     = ST_IDLE;
                    w_cnt_next = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_next     = ST_DONE;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_write   <= 1'b0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == ST_IDLE && w_setup) begin
                r_idx   <= w_dec_idx;
                r_err   <= w_dec_err;
                r_write <= pwrite;
            end
            r_pready  <= w_enter_done;
            r_pslverr <= w_enter_done & w_cur_err;
            r_prdata  <= (w_enter_done && !w_cur_err && !w_cur_write) ? r_regs[w_cur_idx] : '0;
            if (w_commit) begin
                for (int i = 0; i < STRB_WIDTH; i++) begin
                    if (pstrb[i]) begin
                        r_regs[r_idx][8*i +: 8] <= pwdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign prdata      = r_prdata;
    assign pready      = r_pready;
    assign pslverr     = r_pslverr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one instance with no wait states, one with three,
// sharing a single APB bus with separate selects.
module tb_apb_reg_slave;

    logic        pclk    = 1'b0;
    logic        presetn = 1'b0;
    logic [31:0] paddr   = '0;
    logic        psel0   = 1'b0;
    logic        psel1   = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] pwdata  = '0;
    logic [3:0]  pstrb   = '0;
    logic [2:0]  pprot   = 3'b001;

    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1;
    logic        pslverr0, pslverr1;
    logic [1:0]  dbg0, dbg1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    apb_reg_slave #(.WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0), .o_dbg_state(dbg0)
    );

    apb_reg_slave #(.WAIT_STATES(3)) u_dut1 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1), .o_dbg_state(dbg1)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Setup on one falling edge, access from the next; returns at the falling edge inside DONE.
    task automatic apb_xfer(input bit inst, input logic [31:0] addr, input bit wr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err, output int waits);
        logic rdy;
        @(negedge pclk);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        penable = 1'b0;
        psel0   = ~inst;
        psel1   = inst;
        @(negedge pclk);
        penable = 1'b1;
        waits   = 0;
        rdy     = inst ? pready1 : pready0;
        while (!rdy && waits < 40) begin
            @(negedge pclk);
            waits++;
            rdy = inst ? pready1 : pready0;
        end
        check_eq($sformatf("pready_seen_%08h", addr), 32'(rdy), 32'd1);
        rdata = inst ? prdata1 : prdata0;
        err   = inst ? pslverr1 : pslverr0;
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
    endtask

    task automatic write_chk(input string tag, input bit inst, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             input bit exp_err, input int exp_waits);
        logic [31:0] rd;
        logic        err;
        int          w;
        apb_xfer(inst, addr, 1'b1, data, strb, rd, err, w);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_waits"}, 32'(w), 32'(exp_waits));
        check_eq({tag, "_prdata"}, rd, 32'd0);
    endtask

    task automatic read_chk(input string tag, input bit inst, input logic [31:0] addr,
                            input logic [31:0] exp_data, input bit exp_err, input int exp_waits);
        logic [31:0] rd;
        logic        err;
        int          w;
        exp_q.push_back(exp_data);
        apb_xfer(inst, addr, 1'b0, $urandom(), 4'($urandom_range(0, 15)), rd, err, w);
        check_eq({tag, "_data"}, rd, exp_q.pop_front());
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_waits"}, 32'(w), 32'(exp_waits));
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check_eq("rst_pready0", 32'(pready0), 32'd0);
        check_eq("rst_pslverr0", 32'(pslverr0), 32'd0);
        check_eq("rst_prdata0", prdata0, 32'd0);
        check_eq("rst_pready1", 32'(pready1), 32'd0);
        check_eq("rst_state0", 32'(dbg0), 32'd0);
        check_eq("rst_state1", 32'(dbg1), 32'd0);
        presetn = 1'b1;
    endtask

    initial begin
        // Reset and all registers read back as zero
        do_reset();
        for (int i = 0; i < 16; i++) begin
            read_chk($sformatf("rst_reg%0d", i), 1'b0, 32'(i * 4), 32'd0, 1'b0, 0);
        end
        bus_idle();

        // Full word write then read with no wait states
        write_chk("wr08", 1'b0, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, 0);
        read_chk("rd08", 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, 0);
        bus_idle();
        check_eq("prdata_clears", prdata0, 32'd0);
        check_eq("pready_one_cycle", 32'(pready0), 32'd0);

        // Byte strobes
        write_chk("wr04", 1'b0, 32'h04, 32'h11223344, 4'hF, 1'b0, 0);
        write_chk("wr04_strb", 1'b0, 32'h04, 32'hAABBCCDD, 4'b0101, 1'b0, 0);
        read_chk("rd04_strb", 1'b0, 32'h04, 32'h11BB33DD, 1'b0, 0);
        write_chk("wr04_nostrb", 1'b0, 32'h04, 32'h55555555, 4'b0000, 1'b0, 0);
        read_chk("rd04_nostrb", 1'b0, 32'h04, 32'h11BB33DD, 1'b0, 0);
        bus_idle();

        // Bad addresses
        write_chk("wr40_err", 1'b0, 32'h40, 32'hFFFFFFFF, 4'hF, 1'b1, 0);
        read_chk("rd40_err", 1'b0, 32'h40, 32'd0, 1'b1, 0);
        write_chk("wr06_err", 1'b0, 32'h06, 32'hFFFFFFFF, 4'hF, 1'b1, 0);
        read_chk("rd06_err", 1'b0, 32'h06, 32'd0, 1'b1, 0);
        read_chk("rd00_after_err", 1'b0, 32'h00, 32'd0, 1'b0, 0);
        read_chk("rd04_after_err", 1'b0, 32'h04, 32'h11BB33DD, 1'b0, 0);
        read_chk("rd08_after_err", 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, 0);
        bus_idle();

        // Back-to-back write then read of the same register
        write_chk("wr3c_b2b", 1'b0, 32'h3C, 32'hCAFEF00D, 4'hF, 1'b0, 0);
        read_chk("rd3c_b2b", 1'b0, 32'h3C, 32'hCAFEF00D, 1'b0, 0);
        bus_idle();

        // Three wait states
        write_chk("ws3_wr0c", 1'b1, 32'h0C, 32'h12345678, 4'hF, 1'b0, 3);
        read_chk("ws3_rd0c", 1'b1, 32'h0C, 32'h12345678, 1'b0, 3);
        write_chk("ws3_wr44_err", 1'b1, 32'h44, 32'h1, 4'hF, 1'b1, 3);
        bus_idle();

        // Abandon a write during the wait phase
        @(negedge pclk);
        paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        psel1 = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        check_eq("drop_pready_wait", 32'(pready1), 32'd0);
        check_eq("drop_state_wait", 32'(dbg1), 32'd1);
        @(negedge pclk);
        psel1 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check_eq("drop_state_idle", 32'(dbg1), 32'd0);
        check_eq("drop_pready", 32'(pready1), 32'd0);
        read_chk("drop_rd10", 1'b1, 32'h10, 32'd0, 1'b0, 3);
        bus_idle();

        // Protection: unprivileged write
        pprot = 3'b000;
`ifdef APB_PRIV_ONLY_EN
        write_chk("priv_wr_unpriv", 1'b0, 32'h00, 32'h1, 4'hF, 1'b1, 0);
        read_chk("priv_rd_unpriv", 1'b0, 32'h00, 32'd0, 1'b1, 0);
        pprot = 3'b001;
        read_chk("priv_rd00_zero", 1'b0, 32'h00, 32'd0, 1'b0, 0);
`else
        write_chk("priv_wr_unpriv", 1'b0, 32'h00, 32'h1, 4'hF, 1'b0, 0);
        read_chk("priv_rd_unpriv", 1'b0, 32'h00, 32'h1, 1'b0, 0);
        pprot = 3'b001;
`endif
        write_chk("priv_wr_priv", 1'b0, 32'h00, 32'h1, 4'hF, 1'b0, 0);
        read_chk("priv_rd_priv", 1'b0, 32'h00, 32'h1, 1'b0, 0);
        bus_idle();

        // Reset clears registers that were written
        write_chk("pre_rst_wr0c", 1'b0, 32'h0C, 32'h5A5A5A5A, 4'hF, 1'b0, 0);
        read_chk("pre_rst_rd0c", 1'b0, 32'h0C, 32'h5A5A5A5A, 1'b0, 0);
        bus_idle();
        do_reset();
        read_chk("post_rst_rd0c", 1'b0, 32'h0C, 32'd0, 1'b0, 0);
        read_chk("post_rst_rd08", 1'b0, 32'h08, 32'd0, 1'b0, 0);
        bus_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
